// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the ALU sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b10;
    localparam logic [1:0] COND_C      = 2'b01;
    localparam logic [1:0] COND_NEVER  = 2'b11;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_NAND = 1'b1;

endpackage

// File: rtl/alu_seq_cond.sv
// rtl/alu_seq_cond.sv - write-enable decision from condition code and current flags
module alu_seq_cond
    import alu_seq_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       wr_ok
);

    // Select which flag (if any) gates the write-back
    always_comb begin
        wr_ok = 1'b0;
        case (cond)
            COND_ALWAYS: wr_ok = 1'b1;
            COND_Z:      wr_ok = flag_z;
            COND_C:      wr_ok = flag_c;
            COND_NEVER:  wr_ok = 1'b0;
            default:     wr_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - 4-cycle ADD/NAND sequencer; optional ALU_SEQ_SKIP_CNT_EN adds skip_cnt
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              instr_op,
    input  logic [1:0]        instr_cond,
    input  logic              instr_imm,
    input  logic [REG_AW-1:0] instr_ra,
    input  logic [REG_AW-1:0] instr_rb,
    input  logic [REG_AW-1:0] instr_rc,
    input  logic [IMM_W-1:0]  instr_imm6,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic              alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              flag_c,
    output logic              flag_z,
    output logic              done
`ifdef ALU_SEQ_SKIP_CNT_EN
    ,
    output logic [15:0]       skip_cnt
`endif
);

    state_t             state_q;
    logic               op_q;
    logic               imm_q;
    logic [1:0]         cond_q;
    logic [IMM_W-1:0]   imm6_q;
    logic [DATA_W-1:0]  result_q;
    logic               carry_q;
    logic               zero_q;
    logic               wr_q;
    logic               wr_ok;
    logic [DATA_W-1:0]  imm_ext;

    assign imm_ext    = {{(DATA_W-IMM_W){imm6_q[IMM_W-1]}}, imm6_q};
    assign alu_in1    = rf_ra_data;
    assign alu_in2    = imm_q ? imm_ext : rf_rb_data;
    assign alu_op     = op_q;
    assign rf_wr_data = result_q;

    // Condition is judged against the flags left by the previous instruction
    alu_seq_cond u_cond (
        .cond   (cond_q),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .wr_ok  (wr_ok)
    );

    // Sequencer FSM: latch, read RF, execute, write back; all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            instr_ready <= 1'b1;
            rf_wr_en    <= 1'b0;
            done        <= 1'b0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            op_q        <= OP_ADD;
            imm_q       <= 1'b0;
            cond_q      <= COND_ALWAYS;
            imm6_q      <= '0;
            rf_ra_addr  <= '0;
            rf_rb_addr  <= '0;
            rf_wr_addr  <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            wr_q        <= 1'b0;
`ifdef ALU_SEQ_SKIP_CNT_EN
            skip_cnt    <= 16'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q        <= instr_op;
                        imm_q       <= instr_imm;
                        // ADI is unconditional regardless of its cond field
                        cond_q      <= instr_imm ? COND_ALWAYS : instr_cond;
                        imm6_q      <= instr_imm6;
                        rf_ra_addr  <= instr_ra;
                        rf_rb_addr  <= instr_rb;
                        rf_wr_addr  <= instr_rc;
                        instr_ready <= 1'b0;
                        state_q     <= S_READ;
                    end
                end
                S_READ: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    result_q <= alu_out;
                    carry_q  <= alu_carry;
                    zero_q   <= (alu_out == '0);
                    wr_q     <= wr_ok;
                    rf_wr_en <= wr_ok;
                    done     <= 1'b1;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    rf_wr_en    <= 1'b0;
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    if (wr_q) begin
                        flag_z <= zero_q;
                        if (op_q == OP_ADD) begin
                            flag_c <= carry_q;
                        end
                    end
`ifdef ALU_SEQ_SKIP_CNT_EN
                    else begin
                        skip_cnt <= skip_cnt + 16'd1;
                    end
`endif
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with RF and ALU models
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, instr_ready, instr_op, instr_imm;
    logic [1:0]  instr_cond;
    logic [2:0]  instr_ra, instr_rb, instr_rc;
    logic [5:0]  instr_imm6;
    logic [2:0]  rf_ra_addr, rf_rb_addr, rf_wr_addr;
    logic [15:0] rf_ra_data, rf_rb_data, alu_in1, alu_in2, alu_out, rf_wr_data;
    logic        alu_op, alu_carry, rf_wr_en, flag_c, flag_z, done;
`ifdef ALU_SEQ_SKIP_CNT_EN
    logic [15:0] skip_cnt;
`endif

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_cond(instr_cond), .instr_imm(instr_imm),
        .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rc(instr_rc),
        .instr_imm6(instr_imm6),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .flag_c(flag_c), .flag_z(flag_z), .done(done)
`ifdef ALU_SEQ_SKIP_CNT_EN
        , .skip_cnt(skip_cnt)
`endif
    );

    // Environment: register file with one-cycle read latency and a backdoor load port
    logic [15:0] trf [8];
    logic        ld_en = 1'b0;
    logic [2:0]  ld_a;
    logic [15:0] ld_d;
    always @(posedge clk) begin
        rf_ra_data <= trf[rf_ra_addr];
        rf_rb_data <= trf[rf_rb_addr];
        if (ld_en) trf[ld_a] <= ld_d;
        else if (rf_wr_en) trf[rf_wr_addr] <= rf_wr_data;
    end

    // Environment: combinational ADD/NAND ALU
    logic [16:0] alu_sum;
    assign alu_sum   = {1'b0, alu_in1} + {1'b0, alu_in2};
    assign alu_out   = alu_op ? ~(alu_in1 & alu_in2) : alu_sum[15:0];
    assign alu_carry = alu_op ? 1'b0 : alu_sum[16];

    typedef struct {
        logic        wr;
        logic [2:0]  rc;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic [15:0] skip;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [15:0] mrf [8];
    logic        mc, mz;
    int          mskip;
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, last_acc = 0;
    int          acc_q[$];
    bit          flag_pend = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept logger
    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            last_acc = cyc;
            acc_q.push_back(cyc);
        end
        cyc++;
    end

    // Retirement monitor: write-back fields on done, flags one cycle later
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                cur = sb.pop_front();
                check_eq("wr_en", {31'd0, rf_wr_en}, {31'd0, cur.wr});
                if (cur.wr) begin
                    check_eq("wr_addr", {29'd0, rf_wr_addr}, {29'd0, cur.rc});
                    check_eq("wr_data", {16'd0, rf_wr_data}, {16'd0, cur.res});
                end
                check_eq("latency", cyc - last_acc, 3);
                flag_pend = 1;
            end
        end else if (flag_pend) begin
            flag_pend = 0;
            check_eq("flag_c", {31'd0, flag_c}, {31'd0, cur.c});
            check_eq("flag_z", {31'd0, flag_z}, {31'd0, cur.z});
`ifdef ALU_SEQ_SKIP_CNT_EN
            check_eq("skip_cnt", {16'd0, skip_cnt}, {16'd0, cur.skip});
`endif
        end
        if (rst_n && rf_wr_en && !done) check_eq("stray_wr", 1, 0);
    end

    task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d; mrf[a] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mc = 0; mz = 0; mskip = 0;
        sb.delete(); flag_pend = 0;
    endtask

    task automatic issue(input logic op, input logic [1:0] cond, input logic imm,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc,
                         input logic [5:0] imm6, input bit hold);
        exp_t e;
        logic [15:0] a, b;
        logic [16:0] s;
        logic [1:0]  ec;
        int t;
        a  = mrf[ra];
        b  = imm ? {{10{imm6[5]}}, imm6} : mrf[rb];
        ec = imm ? 2'b00 : cond;
        e.wr = (ec == 2'b00) || (ec == 2'b10 && mz) || (ec == 2'b01 && mc);
        s = (op == 1'b0) ? ({1'b0, a} + {1'b0, b}) : {1'b0, ~(a & b)};
        e.res = s[15:0];
        if (e.wr) begin
            mrf[rc] = e.res;
            mz = (e.res == 16'd0);
            if (op == 1'b0) mc = s[16];
        end else begin
            mskip++;
        end
        e.rc = rc; e.c = mc; e.z = mz; e.skip = mskip[15:0];
        sb.push_back(e);
        instr_op = op; instr_cond = cond; instr_imm = imm;
        instr_ra = ra; instr_rb = rb; instr_rc = rc; instr_imm6 = imm6;
        instr_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || flag_pend) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || flag_pend) begin
            check_eq("drain_timeout", 0, 1);
            sb.delete(); flag_pend = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 0; instr_cond = 0; instr_imm = 0;
        instr_ra = 0; instr_rb = 0; instr_rc = 0; instr_imm6 = 0;
        for (int i = 0; i < 8; i++) begin trf[i] = 16'd0; mrf[i] = 16'd0; end
        mc = 0; mz = 0; mskip = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, instr_ready}, 1);
        check_eq("rst_flag_c", {31'd0, flag_c}, 0);
        check_eq("rst_flag_z", {31'd0, flag_z}, 0);
        check_eq("rst_wr_en", {31'd0, rf_wr_en}, 0);
        check_eq("rst_done", {31'd0, done}, 0);

        // ADD r3 = 5 + 3
        set_reg(1, 16'h0005); set_reg(2, 16'h0003);
        issue(OP_ADD, 2'b00, 0, 1, 2, 3, 6'd0, 0);
        wait_idle();

        // ADD overflow to zero, then ADC taken, reset, ADC squashed
        set_reg(5, 16'h8000);
        issue(OP_ADD, 2'b00, 0, 5, 5, 4, 6'd0, 0);
        issue(OP_ADD, 2'b01, 0, 1, 2, 6, 6'd0, 0);
        wait_idle();
        do_reset();
        issue(OP_ADD, 2'b01, 0, 1, 2, 6, 6'd0, 0);
        wait_idle();

        // Set carry, NDZ squashed, NDU to zero keeps carry
        set_reg(0, 16'hFFFF); set_reg(6, 16'h8001);
        issue(OP_ADD, 2'b00, 0, 5, 6, 4, 6'd0, 0);
        issue(OP_NAND, 2'b10, 0, 0, 0, 4, 6'd0, 0);
        issue(OP_NAND, 2'b00, 0, 0, 0, 7, 6'd0, 0);
        wait_idle();

        // ADI 1 + sext(111111) with cond field 11 still writes
        set_reg(1, 16'h0001);
        issue(OP_ADD, 2'b11, 1, 1, 5, 2, 6'b111111, 0);
        wait_idle();

        // Reset during EXEC drops the instruction
        set_reg(7, 16'h1234);
        instr_op = 0; instr_cond = 2'b00; instr_imm = 0;
        instr_ra = 1; instr_rb = 5; instr_rc = 7; instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstx_wr_en", {31'd0, rf_wr_en}, 0);
        check_eq("rstx_done", {31'd0, done}, 0);
        check_eq("rstx_flag_c", {31'd0, flag_c}, 0);
        check_eq("rstx_flag_z", {31'd0, flag_z}, 0);
        rst_n = 1'b1;
        mc = 0; mz = 0; mskip = 0;
        @(negedge clk);
        check_eq("rstx_ready", {31'd0, instr_ready}, 1);
        repeat (4) @(negedge clk);
        check_eq("rstx_r7_kept", {16'd0, trf[7]}, 32'h1234);

        // Back-to-back with valid held; second uses first's result
        set_reg(1, 16'h0010); set_reg(2, 16'h0020);
        acc_q.delete();
        issue(OP_ADD, 2'b00, 0, 1, 2, 3, 6'd0, 1);
        issue(OP_ADD, 2'b00, 0, 3, 2, 4, 6'd0, 0);
        wait_idle();
        check_eq("b2b_count", acc_q.size(), 2);
        if (acc_q.size() == 2) check_eq("b2b_spacing", acc_q[1] - acc_q[0], 4);

        // Random mix
        for (int i = 0; i < 8; i++) set_reg(i[2:0], 16'($urandom));
        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  6'($urandom), 0);
        end
        wait_idle();

`ifdef ALU_SEQ_SKIP_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) issue(OP_ADD, 2'b11, 0, 1, 2, 3, 6'd0, 0);
        wait_idle();
        check_eq("skip_cnt_three", {16'd0, skip_cnt}, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
